// File: rtl/uc_stack_pkg.sv
// Shared opcode encodings, FSM states and ALU constants for the control unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uc_pkg;

  // Low nibble of the opcode selects the non-ALU instruction class;
  // opcode[3]=0 marks an ALU instruction.
  localparam logic [3:0] OPC_LDI  = 4'b1000;
  localparam logic [3:0] OPC_JMP  = 4'b1001;
  localparam logic [3:0] OPC_JZ   = 4'b1010;
  localparam logic [3:0] OPC_JNZ  = 4'b1011;
  localparam logic [3:0] OPC_CALL = 4'b1100;
  localparam logic [3:0] OPC_RET  = 4'b1101;
  // HALT is the only fully decoded opcode; other xx1111 codes are NOPs.
  localparam logic [5:0] OPC_HALT = 6'b111111;

  localparam logic [2:0] OP_NONE = 3'b000;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } state_t;

  // True for ALU-class opcodes.
  function automatic logic is_alu(input logic [5:0] opc);
    return ~opc[3];
  endfunction

endpackage

// File: rtl/uc_stack_if.sv
// Instruction-side inputs and datapath control outputs of the control unit.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is valid every cycle.
interface uc_stack_if #(
  parameter int ADDR_W = 10
);
  logic              z;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] pc_in;
  logic              s_inc;
  logic              s_ret;
  logic              pc_we;
  logic              s_inm;
  logic              we3;
  logic [2:0]        op;
  logic [ADDR_W-1:0] ret_addr;
  logic              fin;
  logic              stack_ovf;
  logic              stack_unf;

  // Instruction memory / datapath side.
  modport master (
    output z, opcode, pc_in,
    input  s_inc, s_ret, pc_we, s_inm, we3, op, ret_addr, fin, stack_ovf, stack_unf
  );

  // Control unit side.
  modport slave (
    input  z, opcode, pc_in,
    output s_inc, s_ret, pc_we, s_inm, we3, op, ret_addr, fin, stack_ovf, stack_unf
  );
endinterface

// File: rtl/uc_stack_ret_stack.sv
// Return-address LIFO: push/pop at the clock edge, top shown combinationally.
// Latency: push/pop visible on top the cycle after the edge; top is 0 when empty.
// Backpressure: none; push when full and pop when empty are ignored.
module ret_stack #(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [SP_W-1:0] SP_ONE  = 1;
  localparam logic [SP_W-2:0] IDX_ONE = 1;

  logic [SP_W-1:0]   sp;
  logic [SP_W-2:0]   top_idx;
  logic [ADDR_W-1:0] mem [STACK_DEPTH];

  assign full    = (sp == SP_W'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp[SP_W-2:0] - IDX_ONE;
  assign top     = empty ? '0 : mem[top_idx];

  // Stack pointer: only the pointer is reset, entries are left stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_ONE;
    end else if (pop && !empty) begin
      sp <= sp - SP_ONE;
    end
  end

  // Entry storage: write at the current pointer on a successful push.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[SP_W-2:0]] <= din;
    end
  end

endmodule

// File: rtl/uc_stack.sv
// Control unit: opcode decode, registered zero flag, CALL/RET stack, run/halt/error FSM.
// Latency: decode is combinational (0 cycles); flag, stack and state update at the next edge.
// Backpressure: none; one instruction per cycle, HALT/ERR stop the PC until reset.
module uc_stack
  import uc_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  uc_stack_if.slave bus
);

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  state_t            state, state_nxt;
  logic              zflag;
  logic              ovf_q, unf_q;
  logic              z_load, ovf_set, unf_set;
  logic              push, pop;
  logic              stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;

  logic              s_inc, s_ret, pc_we, s_inm, we3, fin;
  logic [2:0]        op;

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.pc_in + PC_ONE),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // State, zero flag and sticky stack-error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      zflag <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (z_load)  zflag <= bus.z;
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  // Decode and next state; everything is forced low while reset is held.
  always_comb begin
    s_inc     = 1'b0;
    s_ret     = 1'b0;
    pc_we     = 1'b0;
    s_inm     = 1'b0;
    we3       = 1'b0;
    op        = OP_NONE;
    fin       = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    z_load    = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    state_nxt = state;
    case (state)
      RUN: begin
        pc_we = 1'b1;
        if (is_alu(bus.opcode)) begin
          we3    = 1'b1;
          op     = bus.opcode[2:0];
          s_inc  = 1'b1;
          z_load = 1'b1;
        end else begin
          case (bus.opcode[3:0])
            OPC_LDI: begin
              we3   = 1'b1;
              s_inm = 1'b1;
              s_inc = 1'b1;
            end
            OPC_JMP: s_inc = 1'b0;
            OPC_JZ:  s_inc = ~zflag;
            OPC_JNZ: s_inc = zflag;
            OPC_CALL: begin
              if (stk_full) begin
                pc_we     = 1'b0;
                ovf_set   = 1'b1;
                state_nxt = ERR;
              end else begin
                push = 1'b1;
              end
            end
            OPC_RET: begin
              if (stk_empty) begin
                pc_we     = 1'b0;
                unf_set   = 1'b1;
                state_nxt = ERR;
              end else begin
                s_ret = 1'b1;
                pop   = 1'b1;
              end
            end
            4'b1111: begin
              if (bus.opcode == OPC_HALT) begin
                fin       = 1'b1;
                pc_we     = 1'b0;
                state_nxt = HALT;
              end else begin
                s_inc = 1'b1;
              end
            end
            default: s_inc = 1'b1;
          endcase
        end
      end
      HALT, ERR: fin = 1'b1;
      default:   state_nxt = RUN;
    endcase
    if (!reset) begin
      s_inc   = 1'b0;
      s_ret   = 1'b0;
      pc_we   = 1'b0;
      s_inm   = 1'b0;
      we3     = 1'b0;
      op      = OP_NONE;
      fin     = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      z_load  = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
    end
  end

  assign bus.s_inc     = s_inc;
  assign bus.s_ret     = s_ret;
  assign bus.pc_we     = pc_we;
  assign bus.s_inm     = s_inm;
  assign bus.we3       = we3;
  assign bus.op        = op;
  assign bus.fin       = fin;
  assign bus.ret_addr  = reset ? stk_top : '0;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;

endmodule

// File: tb/tb_uc_stack.sv
module tb_uc_stack;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  // Control word layout: {s_inc, s_ret, pc_we, s_inm, we3, op[2:0], fin, stack_ovf, stack_unf}
  typedef struct {
    bit          rst;
    bit          z;
    logic [5:0]  opc;
    logic [AW-1:0] pc;
    logic [10:0] ctl;
    logic [AW-1:0] ret;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uc_stack_if #(.ADDR_W(AW)) bus();

  uc_stack #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model state.
  localparam int M_RUN = 0, M_HALT = 1, M_ERR = 2;
  int            m_state;
  bit            m_z, m_ovf, m_unf;
  logic [AW-1:0] m_q[$];

  task automatic add(input bit rst, input bit z, input logic [5:0] opc,
                     input logic [AW-1:0] pc, input logic [10:0] ctl, input logic [AW-1:0] ret);
    vec_t v;
    v.rst = rst; v.z = z; v.opc = opc; v.pc = pc; v.ctl = ctl; v.ret = ret;
    tbl.push_back(v);
  endtask

  task automatic drive(input bit rst, input bit z, input logic [5:0] opc, input logic [AW-1:0] pc);
    reset      = ~rst;
    bus.z      = z;
    bus.opcode = opc;
    bus.pc_in  = pc;
  endtask

  task automatic check(input string name, input logic [10:0] ctl, input logic [AW-1:0] ret);
    logic [10:0] act;
    act = {bus.s_inc, bus.s_ret, bus.pc_we, bus.s_inm, bus.we3, bus.op,
           bus.fin, bus.stack_ovf, bus.stack_unf};
    n_vec++;
    if (act !== ctl || bus.ret_addr !== ret) begin
      n_miss++;
      $display("FAIL %s: got ctl=%b ret=%h, want ctl=%b ret=%h", name, act, bus.ret_addr, ctl, ret);
    end
  endtask

  task automatic model_reset();
    m_state = M_RUN;
    m_z = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_q.delete();
  endtask

  // Expected outputs for the current inputs, from the instruction-level rules.
  task automatic model_expect(input bit rst, input logic [5:0] opc,
                              output logic [10:0] ctl, output logic [AW-1:0] ret);
    bit inc, sret, we, inm, w3, f;
    logic [2:0] aop;
    inc = 0; sret = 0; we = 0; inm = 0; w3 = 0; f = 0; aop = 3'b000;
    ret = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
    if (m_state != M_RUN) begin
      f = 1;
    end else begin
      we = 1;
      if (opc[3] == 1'b0) begin
        w3 = 1; aop = opc[2:0]; inc = 1;
      end else begin
        case (int'(opc[3:0]))
          8:  begin w3 = 1; inm = 1; inc = 1; end
          9:  inc = 0;
          10: inc = !m_z;
          11: inc = m_z;
          12: if (m_q.size() >= DEPTH) we = 0;
          13: if (m_q.size() == 0) we = 0; else sret = 1;
          15: if (opc == 6'b111111) begin f = 1; we = 0; end else inc = 1;
          default: inc = 1;
        endcase
      end
    end
    ctl = {inc, sret, we, inm, w3, aop, f, m_ovf, m_unf};
    if (rst) begin
      ctl = '0;
      ret = '0;
    end
  endtask

  // Clock-edge effects on the model.
  task automatic model_update(input bit rst, input bit z, input logic [5:0] opc, input logic [AW-1:0] pc);
    if (rst) begin
      model_reset();
    end else if (m_state == M_RUN) begin
      if (opc[3] == 1'b0) m_z = z;
      else if (opc[3:0] == 4'b1100) begin
        if (m_q.size() >= DEPTH) begin m_ovf = 1; m_state = M_ERR; end
        else m_q.push_back(pc + AW'(1));
      end else if (opc[3:0] == 4'b1101) begin
        if (m_q.size() == 0) begin m_unf = 1; m_state = M_ERR; end
        else void'(m_q.pop_back());
      end else if (opc == 6'b111111) m_state = M_HALT;
    end
  endtask

  initial begin
    logic [10:0]   e_ctl;
    logic [AW-1:0] e_ret;
    bit            r_rst, r_z;
    logic [5:0]    r_opc;
    logic [AW-1:0] r_pc;
    int            sel;

    drive(1, 0, 6'd0, '0);

    // ---------------- directed table ----------------
    add(1, 0, 6'b000000, 10'h000, 11'b00000_000_000, 10'h000);
    add(0, 1, 6'b000010, 10'h000, 11'b10101_010_000, 10'h000); // ALU, z=1
    add(0, 0, 6'b001010, 10'h000, 11'b00100_000_000, 10'h000); // JZ jumps
    add(0, 0, 6'b000010, 10'h000, 11'b10101_010_000, 10'h000); // ALU, z=0
    add(0, 1, 6'b001010, 10'h000, 11'b10100_000_000, 10'h000); // JZ falls through, live z ignored
    add(0, 1, 6'b001011, 10'h000, 11'b00100_000_000, 10'h000); // JNZ jumps
    add(0, 1, 6'b000111, 10'h000, 11'b10101_111_000, 10'h000); // ALU, z=1
    add(0, 0, 6'b001000, 10'h000, 11'b10111_000_000, 10'h000); // LDI
    add(0, 0, 6'b001010, 10'h000, 11'b00100_000_000, 10'h000); // JZ still jumps
    add(0, 0, 6'b001100, 10'h005, 11'b00100_000_000, 10'h000); // CALL
    add(0, 0, 6'b001110, 10'h020, 11'b10100_000_000, 10'h006); // NOP
    add(0, 0, 6'b001101, 10'h020, 11'b01100_000_000, 10'h006); // RET
    add(0, 0, 6'b001111, 10'h021, 11'b10100_000_000, 10'h000); // NOP (xx1111)
    for (int i = 1; i <= 4; i++)
      add(0, 0, 6'b001100, AW'(i), 11'b00100_000_000, (i == 1) ? 10'h000 : AW'(i));
    for (int i = 0; i < 4; i++)
      add(0, 0, 6'b001101, 10'h030, 11'b01100_000_000, AW'(5 - i));
    add(0, 0, 6'b001110, 10'h000, 11'b10100_000_000, 10'h000);
    for (int i = 1; i <= 4; i++)
      add(0, 0, 6'b001100, AW'(i), 11'b00100_000_000, (i == 1) ? 10'h000 : AW'(i));
    add(0, 0, 6'b001100, 10'h007, 11'b00000_000_000, 10'h005); // CALL when full
    add(0, 1, 6'b000001, 10'h000, 11'b00000_000_110, 10'h005); // ERR
    add(0, 0, 6'b111111, 10'h000, 11'b00000_000_110, 10'h005); // still ERR
    add(1, 0, 6'b000000, 10'h000, 11'b00000_000_000, 10'h000);
    add(0, 0, 6'b001101, 10'h000, 11'b00000_000_000, 10'h000); // RET when empty
    add(0, 0, 6'b001000, 10'h000, 11'b00000_000_101, 10'h000); // ERR
    add(1, 0, 6'b000000, 10'h000, 11'b00000_000_000, 10'h000);
    add(0, 0, 6'b111111, 10'h000, 11'b00000_000_100, 10'h000); // HALT
    add(0, 1, 6'b000011, 10'h000, 11'b00000_000_100, 10'h000); // ignored
    add(1, 0, 6'b001100, 10'h3FF, 11'b00000_000_000, 10'h000); // CALL under reset
    add(0, 0, 6'b001110, 10'h000, 11'b10100_000_000, 10'h000); // no push happened
    add(0, 0, 6'b001100, 10'h3FF, 11'b00100_000_000, 10'h000); // CALL, pc wraps
    add(0, 0, 6'b001101, 10'h100, 11'b01100_000_000, 10'h000); // RET to 0x000
    add(0, 0, 6'b011110, 10'h000, 11'b10100_000_000, 10'h000); // NOP
    add(0, 0, 6'b101111, 10'h000, 11'b10100_000_000, 10'h000); // NOP
    add(0, 0, 6'b110101, 10'h000, 11'b10101_101_000, 10'h000); // ALU op 101

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i].rst, tbl[i].z, tbl[i].opc, tbl[i].pc);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].ctl, tbl[i].ret);
    end

    // ---------------- asynchronous reset mid-cycle ----------------
    @(posedge clk); #1;
    drive(0, 1, 6'b000000, 10'h000);
    @(negedge clk);
    check("alu_z1", 11'b10101_000_000, 10'h000);
    @(posedge clk); #1;
    drive(0, 0, 6'b111111, 10'h000);
    @(negedge clk);
    check("halt_same_cycle", 11'b00000_000_100, 10'h000);
    #2 reset = 1'b0;
    #1 check("async_reset_now", 11'b00000_000_000, 10'h000);
    @(posedge clk); #1;
    drive(0, 0, 6'b001010, 10'h000);
    @(negedge clk);
    check("jz_after_reset", 11'b10100_000_000, 10'h000);

    // ---------------- randomized against the model ----------------
    @(posedge clk); #1;
    drive(1, 0, 6'd0, '0);
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      r_rst = ($urandom_range(0, 29) == 0);
      r_z   = 1'($urandom);
      r_pc  = AW'($urandom);
      sel   = $urandom_range(0, 9);
      if (sel < 3)      r_opc = {2'($urandom), 4'b1100};
      else if (sel < 5) r_opc = {2'($urandom), 4'b1101};
      else              r_opc = 6'($urandom);
      if (r_opc == 6'b111111 && $urandom_range(0, 3) != 0) r_opc = 6'b001110;
      drive(r_rst, r_z, r_opc, r_pc);
      @(negedge clk);
      model_expect(r_rst, r_opc, e_ctl, e_ret);
      check($sformatf("rnd%0d", i), e_ctl, e_ret);
      model_update(r_rst, r_z, r_opc, r_pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uc_stack.md
Name: uc_stack

Overview:
- Next-generation control unit for the 16-bit microcontroller datapath. It replaces the purely combinational decoder.
- Decodes the 6-bit opcode into PC-mux, register-file and ALU controls, same as before.
- Adds a registered zero flag, CALL/RET through a parametrised return-address stack, and a run/halt/error state machine.
- Sits between instruction memory (opcode field) and datapath (PC mux, register file, ALU).

Parameters:
- ADDR_W, 10, PC / jump-address width (jump field of the instruction is [15:6]).
- STACK_DEPTH, 4, number of return-address entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- z  in  1  ALU zero output of the current cycle.
- opcode  in  6  instruction opcode field.
- pc_in  in  ADDR_W  current PC value (source of return address).
- s_inc  out  1  PC mux: 1 selects PC+1, 0 selects the instruction jump field.
- s_ret  out  1  PC mux override: 1 selects ret_addr (priority over s_inc).
- pc_we  out  1  PC register load enable.
- s_inm  out  1  register-file write-data mux: 1 selects immediate, 0 selects ALU.
- we3  out  1  register-file write enable.
- op  out  3  ALU operation.
- ret_addr  out  ADDR_W  top-of-stack return address.
- fin  out  1  program finished or stopped on error.
- stack_ovf  out  1  sticky: CALL with stack full.
- stack_unf  out  1  sticky: RET with stack empty.

Behaviour:
- Reset (reset=0, async):
  - State goes to RUN.
  - zflag=0, sp=0, stack_ovf=0, stack_unf=0.
  - Stack contents are don't-care.
  - All outputs are 0 while reset is low, including pc_we and ret_addr.
- States: RUN, HALT, ERR.
  - Decode is combinational from the opcode in RUN: zero latency, one instruction per cycle.
  - Registered side effects (zflag, stack, sp, state) take effect at the next rising edge.
- Decode in RUN; pc_we=1 unless stated. Defaults: s_ret=0, we3=0, s_inm=0, op=000, fin=0.
  - xx0xxx ALU op:
    - we3=1, op=opcode[2:0], s_inc=1.
    - zflag<=z at the clock edge.
  - xx1000 load immediate: we3=1, s_inm=1, s_inc=1. zflag is unchanged.
  - xx1001 JMP: s_inc=0.
  - xx1010 JZ: s_inc = ~zflag (jump when zflag=1).
  - xx1011 JNZ: s_inc = zflag (jump when zflag=0).
  - xx1100 CALL:
    - Stack not full: push (pc_in+1) mod 2^ADDR_W, sp++, s_inc=0.
    - Stack full: no push, stack_ovf<=1, pc_we=0, state<=ERR.
  - xx1101 RET:
    - Stack not empty: s_ret=1, pop, sp--.
    - Stack empty: stack_unf<=1, pc_we=0, state<=ERR.
  - 111111 HALT: fin=1, pc_we=0, state<=HALT.
  - Any other code (xx1110, and xx1111 other than 111111): NOP with s_inc=1.
- The conditional jumps test only the registered zflag, never the live z input.
- HALT and ERR:
  - fin=1, pc_we=0, we3=0, s_ret=0, s_inc=0.
  - The opcode is ignored.
  - Both states are exited only by reset.
  - The error flags stay asserted in ERR.
- ret_addr always shows stack[sp-1] when sp>0, and 0 when sp=0.
- Full means sp=STACK_DEPTH; sp has width $clog2(STACK_DEPTH)+1. Entries never wrap.
- Reset asserted mid-CALL/RET: no push or pop occurs, and sp returns to 0.

Decomposition:
- Package uc_pkg holds:
  - Opcode constants/masks: OPC_LDI, OPC_JMP, OPC_JZ, OPC_JNZ, OPC_CALL, OPC_RET, OPC_HALT.
  - State enum {RUN, HALT, ERR}.
  - ALU op constant OP_NONE=3'b000.
- One sub-module, ret_stack: a LIFO with push, pop, din, top, full, empty, parametrised by ADDR_W and STACK_DEPTH.
  - Async active-low reset clears the pointer only.
- uc_stack holds the FSM, zflag and decode.

Test Plan:
- ALU op 000010 with z=1, then JZ 001010 → the ALU cycle gives we3=1, op=010, s_inc=1. The next cycle gives s_inc=0. Repeat with z=0 → JZ gives s_inc=1 and JNZ gives s_inc=0.
- pc_in=0x005, CALL 001100 → s_inc=0, then ret_addr=0x006. At pc_in=0x020, RET 001101 → s_ret=1, pc_we=1, then sp=0 and ret_addr=0.
- Four nested CALLs at pc_in=1,2,3,4, then four RETs → ret_addr sequence 5,4,3,2, stack_unf=0.
  - A fifth CALL with the stack full → stack_ovf=1, fin=1, pc_we=0 from the next cycle, held until reset.
- RET with an empty stack after reset → stack_unf=1, state ERR, fin=1.
- HALT 111111 → fin=1 and pc_we=0 the same cycle. A subsequent ALU opcode gives we3=0.
  - Drop reset asynchronously (mid-cycle) → all outputs 0 immediately. After release, RUN resumes with zflag=0.
- LDI 001000 after an ALU op with z=1 → s_inm=1, we3=1. The following JZ still jumps (zflag preserved).
